// File: rtl/norm_ctrl_pkg.sv
// Shared definitions for the norm_ctrl mantissa normalizer: widths and FSM state encoding.
package norm_ctrl_pkg;

    localparam int MANT_W  = 32;
    localparam int EXP_W   = 8;
    localparam int SHAMT_W = 5;
    localparam int HALF_W  = MANT_W / 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN_HI,
        ST_SCAN_LO,
        ST_SHIFT,
        ST_DONE
    } state_t;

endpackage

// File: rtl/norm_ctrl_lzc16.sv
// lzc_16: reports the index of the most-significant set bit of a 16-bit word and whether any bit is set.
module lzc_16 (
    input  logic [15:0] i_data,
    output logic [3:0]  o_c,
    output logic        o_v
);

    // Ascending scan so the highest set bit is the last one to write o_c
    always_comb begin
        o_c = '0;
        o_v = |i_data;
        for (int i = 0; i < 16; i++) begin
            if (i_data[i]) begin
                o_c = 4'(i);
            end
        end
    end

endmodule

// File: rtl/norm_ctrl.sv
// norm_ctrl: multi-cycle mantissa normalizer that time-shares one lzc_16 over the upper and lower halves.
// Optional macro NORM_CTRL_FASTPATH_EN sends operands with the top bit already set straight to DONE.
module norm_ctrl
    import norm_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [MANT_W-1:0]    in_mant,
    input  logic [EXP_W-1:0]     in_exp,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [MANT_W-1:0]    out_mant,
    output logic [EXP_W-1:0]     out_exp,
    output logic [SHAMT_W-1:0]   out_shamt,
    output logic                 out_zero,
    output logic                 busy
);

    localparam logic [SHAMT_W-1:0] HI_BASE = SHAMT_W'(15);
    localparam logic [SHAMT_W-1:0] LO_BASE = SHAMT_W'(31);

    state_t               r_state;
    logic [MANT_W-1:0]    r_mant;
    logic [EXP_W-1:0]     r_exp;
    logic [SHAMT_W-1:0]   r_shamt;
    logic                 r_in_ready;
    logic                 r_busy;
    logic                 r_out_valid;
    logic [MANT_W-1:0]    r_out_mant;
    logic [EXP_W-1:0]     r_out_exp;
    logic [SHAMT_W-1:0]   r_out_shamt;
    logic                 r_out_zero;

    logic [HALF_W-1:0]    w_lzc_in;
    logic [3:0]           w_lzc_c;
    logic                 w_lzc_v;
    logic [EXP_W-1:0]     w_shamt_ext;
    logic                 w_fits;

    // The single counter looks at the low half only while in SCAN_LO
    assign w_lzc_in    = (r_state == ST_SCAN_LO) ? r_mant[HALF_W-1:0] : r_mant[MANT_W-1:HALF_W];
    assign w_shamt_ext = {{(EXP_W-SHAMT_W){1'b0}}, r_shamt};
    assign w_fits      = (w_shamt_ext <= r_exp);

    lzc_16 u_lzc (
        .i_data (w_lzc_in),
        .o_c    (w_lzc_c),
        .o_v    (w_lzc_v)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_mant      <= '0;
            r_exp       <= '0;
            r_shamt     <= '0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_mant  <= '0;
            r_out_exp   <= '0;
            r_out_shamt <= '0;
            r_out_zero  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_mant     <= in_mant;
                        r_exp      <= in_exp;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
`ifdef NORM_CTRL_FASTPATH_EN
                        if (in_mant[MANT_W-1]) begin
                            r_out_mant  <= in_mant;
                            r_out_exp   <= in_exp;
                            r_out_shamt <= '0;
                            r_out_zero  <= 1'b0;
                            r_out_valid <= 1'b1;
                            r_state     <= ST_DONE;
                        end else begin
                            r_state <= ST_SCAN_HI;
                        end
`else
                        r_state <= ST_SCAN_HI;
`endif
                    end
                end
                ST_SCAN_HI: begin
                    if (w_lzc_v) begin
                        r_shamt <= HI_BASE - {1'b0, w_lzc_c};
                        r_state <= ST_SHIFT;
                    end else begin
                        r_state <= ST_SCAN_LO;
                    end
                end
                ST_SCAN_LO: begin
                    if (w_lzc_v) begin
                        r_shamt <= LO_BASE - {1'b0, w_lzc_c};
                        r_state <= ST_SHIFT;
                    end else begin
                        r_out_mant  <= '0;
                        r_out_exp   <= '0;
                        r_out_shamt <= '0;
                        r_out_zero  <= 1'b1;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end
                end
                // When the exponent cannot absorb the full shift, stop at exponent zero (denormal)
                ST_SHIFT: begin
                    if (w_fits) begin
                        r_out_mant  <= r_mant << r_shamt;
                        r_out_exp   <= r_exp - w_shamt_ext;
                        r_out_shamt <= r_shamt;
                    end else begin
                        r_out_mant  <= r_mant << r_exp;
                        r_out_exp   <= '0;
                        r_out_shamt <= r_exp[SHAMT_W-1:0];
                    end
                    r_out_zero  <= 1'b0;
                    r_out_valid <= 1'b1;
                    r_state     <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign busy      = r_busy;
    assign out_valid = r_out_valid;
    assign out_mant  = r_out_mant;
    assign out_exp   = r_out_exp;
    assign out_shamt = r_out_shamt;
    assign out_zero  = r_out_zero;

endmodule

// File: tb/tb_norm_ctrl.sv
// Scoreboard bench for norm_ctrl: random operands, reference normalizer model, decoupled monitor.
module tb_norm_ctrl;

    typedef struct {
        logic [31:0] mant;
        logic [7:0]  exp;
        logic [4:0]  shamt;
        logic        zero;
        int          lat;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_mant = '0;
    logic [7:0]  in_exp = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_mant;
    logic [7:0]  out_exp;
    logic [4:0]  out_shamt;
    logic        out_zero;
    logic        busy;

    int   nVectors = 0;
    int   nMiss = 0;
    int   cyc = 0;
    int   forceHold = 0;
    exp_t sbQueue[$];

    norm_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mant   (in_mant),
        .in_exp    (in_exp),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mant  (out_mant),
        .out_exp   (out_exp),
        .out_shamt (out_shamt),
        .out_zero  (out_zero),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nVectors++;
        if (actual !== expected) begin
            nMiss++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Reference: normalise by counting leading zeros, clamp the shift to the exponent
    function automatic exp_t model(input logic [31:0] m, input logic [7:0] e, input int acc);
        exp_t r;
        int   lz;
        lz = 32;
        for (int i = 0; i < 32; i++) if (m[i]) lz = 31 - i;
        r.acc = acc;
        if (m == 0) begin
            r.mant = 0; r.exp = 0; r.shamt = 0; r.zero = 1'b1; r.lat = 3;
        end else begin
            r.zero = 1'b0;
            if (lz <= int'(e)) begin
                r.mant = m << lz; r.exp = 8'(int'(e) - lz); r.shamt = 5'(lz);
            end else begin
                r.mant = m << e; r.exp = 0; r.shamt = 5'(e);
            end
            r.lat = (m[31:16] != 0) ? 3 : 4;
`ifdef NORM_CTRL_FASTPATH_EN
            if (m[31]) r.lat = 1;
`endif
        end
        return r;
    endfunction

    // Called just after a negedge; returns just after the negedge following the accept
    task automatic applyStimulus(input logic [31:0] m, input logic [7:0] e, input bit expectOut);
        int waited = 0;
        in_mant  = m;
        in_exp   = e;
        in_valid = 1'b1;
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            checkOutput("accept_timeout", 32'(in_ready), 32'd1);
        end else begin
            if (expectOut) sbQueue.push_back(model(m, e, cyc));
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic waitIdle();
        int waited = 0;
        while ((sbQueue.size() != 0 || !in_ready) && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 500) checkOutput("drain_timeout", 32'(sbQueue.size()), 32'd0);
    endtask

    // Monitor: pops on the first cycle of each result, then checks stability while held
    initial begin : monitor
        exp_t cur;
        bit   fresh = 1'b1;
        logic [31:0] hMant;
        logic [7:0]  hExp;
        logic [4:0]  hShamt;
        logic        hZero;
        forever begin
            @(negedge clk);
            if (rst || !out_valid) begin
                fresh = 1'b1;
            end else begin
                checkOutput("in_ready_low_while_valid", 32'(in_ready), 32'd0);
                if (fresh) begin
                    if (sbQueue.size() == 0) begin
                        checkOutput("unexpected_output", 32'd1, 32'd0);
                    end else begin
                        cur = sbQueue.pop_front();
                        checkOutput("out_mant", out_mant, cur.mant);
                        checkOutput("out_exp", 32'(out_exp), 32'(cur.exp));
                        checkOutput("out_shamt", 32'(out_shamt), 32'(cur.shamt));
                        checkOutput("out_zero", 32'(out_zero), 32'(cur.zero));
                        checkOutput("latency", 32'(cyc - cur.acc), 32'(cur.lat));
                    end
                    fresh = 1'b0;
                end else begin
                    checkOutput("hold_mant", out_mant, hMant);
                    checkOutput("hold_exp", 32'(out_exp), 32'(hExp));
                    checkOutput("hold_shamt", 32'(out_shamt), 32'(hShamt));
                    checkOutput("hold_zero", 32'(out_zero), 32'(hZero));
                end
                hMant = out_mant; hExp = out_exp; hShamt = out_shamt; hZero = out_zero;
            end
            if (out_valid && forceHold > 0) begin
                out_ready = 1'b0;
                forceHold--;
            end else begin
                out_ready = ($urandom_range(0, 3) != 0);
            end
            if (out_valid && out_ready) fresh = 1'b1;
        end
    end

    initial begin : driver
        logic [31:0] m;
        logic [7:0]  e;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_out_mant", out_mant, 32'd0);
        checkOutput("reset_out_exp", 32'(out_exp), 32'd0);
        checkOutput("reset_out_shamt", 32'(out_shamt), 32'd0);
        checkOutput("reset_out_zero", 32'(out_zero), 32'd0);

        applyStimulus(32'h0001_0000, 8'd40, 1'b1);
        applyStimulus(32'h0000_0003, 8'd100, 1'b1);
        applyStimulus(32'h0000_0001, 8'd10, 1'b1);
        waitIdle();
        forceHold = 5;
        applyStimulus(32'h0000_0000, 8'd77, 1'b1);
        waitIdle();

        for (int n = 0; n < 200; n++) begin
            case ($urandom_range(0, 4))
                0: m = $urandom;
                1: m = $urandom & 32'h0000_FFFF;
                2: m = $urandom_range(0, 15);
                3: m = $urandom | 32'h8000_0000;
                default: m = ($urandom_range(0, 2) == 0) ? 32'd0 : (32'd1 << $urandom_range(0, 31));
            endcase
            e = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 20));
            applyStimulus(m, e, 1'b1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        waitIdle();

        // Reset while in SCAN_LO must discard the operation silently
        applyStimulus(32'h0000_0003, 8'd50, 1'b0);
        @(negedge clk);
        checkOutput("busy_mid_scan", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_in_ready", 32'(in_ready), 32'd1);
        applyStimulus(32'h8000_0000, 8'd5, 1'b1);
        waitIdle();
        repeat (4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiss);
        $finish;
    end

endmodule
